rtc_multi_alarm: RTL and testbench

Parametrised successor to the single-counter RTC core: a prescaled free-running time counter with `ALARM_NUM` independent compare channels, each one-shot or periodic, with sticky pending flags and a combined interrupt. It sits behind the register slice of the next-generation RTC peripheral. It runs entirely in one clock domain.

---
 rtl/rtc_alarm_pkg.sv | 19 +
 rtl/rtc_prescaler.sv | 32 +++
 rtl/rtc_multi_alarm.sv | 117 +++++++++++
 tb/tb_rtc_multi_alarm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_alarm_pkg.sv
// Shared types and helpers for the multi-channel RTC alarm core.
// The channel record width is fixed here and sets the compare/period width of the core.
package rtc_alarm_pkg;

    localparam int ALARM_CNT_WIDTH = 32;

    typedef struct packed {
        logic [ALARM_CNT_WIDTH-1:0] cmp;
        logic [ALARM_CNT_WIDTH-1:0] per;
        logic                       en;
    } alarm_ch_t;

    localparam alarm_ch_t ALARM_CH_RST = '{cmp: '0, per: '0, en: 1'b0};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Clock prescaler: counts enabled cycles and emits a one-cycle tick strobe
// every psc_i+1 enabled cycles. A clear restarts the count and suppresses the tick.
module rtc_prescaler #(
    parameter int PSC_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic                 clr_i,
    output logic                 tick_o
);

    logic [PSC_WIDTH-1:0] psc_cnt;
    logic                 hit;

    // An exact compare: if psc_i shrinks below psc_cnt, the count runs on and wraps first.
    assign hit    = en_i && (psc_cnt == psc_i);
    assign tick_o = hit && !clr_i;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_cnt <= '0;
        end else if (clr_i) begin
            psc_cnt <= '0;
        end else if (en_i) begin
            psc_cnt <= hit ? '0 : psc_cnt + PSC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rtc_multi_alarm.sv
// Prescaled free-running time counter with ALARM_NUM compare channels (one-shot or
// periodic), sticky pending flags and a combined interrupt.
module rtc_multi_alarm
    import rtc_alarm_pkg::*;
#(
    parameter int  CNT_WIDTH = ALARM_CNT_WIDTH,
    parameter int  PSC_WIDTH = 16,
    parameter int  ALARM_NUM = 4,
    localparam int IDX_WIDTH = idx_width(ALARM_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic                 cnt_wr_i,
    input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 tick_o,
    input  logic                 alrm_wr_i,
    input  logic [IDX_WIDTH-1:0] alrm_idx_i,
    input  logic [CNT_WIDTH-1:0] alrm_cmp_i,
    input  logic [CNT_WIDTH-1:0] alrm_per_i,
    input  logic                 alrm_en_i,
    output logic [CNT_WIDTH-1:0] alrm_cmp_o,
    input  logic [ALARM_NUM-1:0] alrm_clr_i,
    output logic [ALARM_NUM-1:0] alrm_pend_o,
    output logic                 irq_o
);

    logic                 tick;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 tick_q;
    logic [ALARM_NUM-1:0] match;
    logic [ALARM_NUM-1:0] pend_q;
    logic [CNT_WIDTH-1:0] cmp_arr [ALARM_NUM];

    // A counter load restarts the prescaler and masks the tick, so a load never fires an alarm.
    rtc_prescaler #(
        .PSC_WIDTH (PSC_WIDTH)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .psc_i  (psc_i),
        .clr_i  (cnt_wr_i),
        .tick_o (tick)
    );

    assign cnt_next = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick;
            if (cnt_wr_i) begin
                cnt_q <= cnt_wdata_i;
            end else if (tick) begin
                cnt_q <= cnt_next;
            end
        end
    end

    for (genvar k = 0; k < ALARM_NUM; k++) begin : g_ch
        alarm_ch_t ch_q;
        logic      wr_sel;

        assign wr_sel   = alrm_wr_i && (int'(alrm_idx_i) == k);
        // Alarms compare against the value the counter is about to show; a write to
        // this channel in the same cycle takes precedence and drops the match.
        assign match[k] = tick && ch_q.en && (ch_q.cmp == cnt_next) && !wr_sel;
        assign cmp_arr[k] = ch_q.cmp;

        // NOTE: the channel array is small control state, so every entry is reset
        // explicitly rather than left to software initialisation like a RAM.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ch_q <= ALARM_CH_RST;
            end else if (wr_sel) begin
                ch_q <= '{cmp: alrm_cmp_i, per: alrm_per_i, en: alrm_en_i};
            end else if (match[k]) begin
                if (ch_q.per != '0) begin
                    ch_q.cmp <= ch_q.cmp + ch_q.per;
                end else begin
                    ch_q.en <= 1'b0;
                end
            end
        end
    end

    // Set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~alrm_clr_i) | match;
        end
    end

    // NOTE: the output is given a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        alrm_cmp_o = '0;
        for (int k = 0; k < ALARM_NUM; k++) begin
            if (int'(alrm_idx_i) == k) begin
                alrm_cmp_o = cmp_arr[k];
            end
        end
    end

    assign cnt_o       = cnt_q;
    assign tick_o      = tick_q;
    assign alrm_pend_o = pend_q;
    assign irq_o       = |pend_q;

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Self-checking bench for rtc_multi_alarm: a behavioural reference model predicts each
// cycle's outputs into a scoreboard queue; directed scenarios add fixed-value checks.
module tb_rtc_multi_alarm;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] psc;
    logic        cnt_wr;
    logic [31:0] cnt_wdata;
    logic [31:0] cnt_o;
    logic        tick_o;
    logic        alrm_wr;
    logic [1:0]  alrm_idx;
    logic [31:0] alrm_cmp;
    logic [31:0] alrm_per;
    logic        alrm_en;
    logic [31:0] alrm_cmp_o;
    logic [3:0]  alrm_clr;
    logic [3:0]  alrm_pend_o;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_multi_alarm #(
        .CNT_WIDTH (32),
        .PSC_WIDTH (16),
        .ALARM_NUM (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .psc_i       (psc),
        .cnt_wr_i    (cnt_wr),
        .cnt_wdata_i (cnt_wdata),
        .cnt_o       (cnt_o),
        .tick_o      (tick_o),
        .alrm_wr_i   (alrm_wr),
        .alrm_idx_i  (alrm_idx),
        .alrm_cmp_i  (alrm_cmp),
        .alrm_per_i  (alrm_per),
        .alrm_en_i   (alrm_en),
        .alrm_cmp_o  (alrm_cmp_o),
        .alrm_clr_i  (alrm_clr),
        .alrm_pend_o (alrm_pend_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cnt;
        logic        tick;
        logic [3:0]  pend;
        logic        irq;
        logic [31:0] cmp_o;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [15:0] m_psc;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp [4];
    logic [31:0] m_per [4];
    logic        m_en  [4];
    logic [3:0]  m_pend;
    logic        m_tick;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step();
        logic        t;
        logic [31:0] nc;
        logic [3:0]  set;
        t   = 1'b0;
        set = '0;
        if (rst) begin
            m_psc  = '0;
            m_cnt  = '0;
            m_pend = '0;
            m_tick = 1'b0;
            for (int k = 0; k < 4; k++) begin
                m_cmp[k] = '0;
                m_per[k] = '0;
                m_en[k]  = 1'b0;
            end
        end else begin
            if (cnt_wr) begin
                m_psc = '0;
            end else if (en) begin
                if (m_psc == psc) begin
                    m_psc = '0;
                    t     = 1'b1;
                end else begin
                    m_psc = m_psc + 16'd1;
                end
            end
            nc = m_cnt + 32'd1;
            for (int k = 0; k < 4; k++) begin
                if (alrm_wr && (alrm_idx == 2'(k))) begin
                    m_cmp[k] = alrm_cmp;
                    m_per[k] = alrm_per;
                    m_en[k]  = alrm_en;
                end else if (t && m_en[k] && (m_cmp[k] == nc)) begin
                    set[k] = 1'b1;
                    if (m_per[k] != 0) m_cmp[k] = m_cmp[k] + m_per[k];
                    else               m_en[k]  = 1'b0;
                end
            end
            if (cnt_wr)  m_cnt = cnt_wdata;
            else if (t)  m_cnt = nc;
            m_pend = (m_pend & ~alrm_clr) | set;
            m_tick = t;
        end
    endfunction

    // One clock: predict, push, clock the DUT, pop and compare.
    task automatic step();
        exp_t e;
        model_step();
        e.cnt   = m_cnt;
        e.tick  = m_tick;
        e.pend  = m_pend;
        e.irq   = |m_pend;
        e.cmp_o = m_cmp[alrm_idx];
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_cnt",   cnt_o,       e.cnt);
        check("sb_tick",  tick_o,      e.tick);
        check("sb_pend",  alrm_pend_o, e.pend);
        check("sb_irq",   irq_o,       e.irq);
        check("sb_cmp_o", alrm_cmp_o,  e.cmp_o);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ch(input logic [1:0] idx, input logic [31:0] cmp,
                          input logic [31:0] per, input logic chen);
        alrm_wr  = 1'b1;
        alrm_idx = idx;
        alrm_cmp = cmp;
        alrm_per = per;
        alrm_en  = chen;
    endtask

    task automatic idle_inputs();
        cnt_wr   = 1'b0;
        alrm_wr  = 1'b0;
        alrm_clr = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; psc = '0; cnt_wr = 1'b0; cnt_wdata = '0;
        alrm_wr = 1'b0; alrm_idx = '0; alrm_cmp = '0; alrm_per = '0; alrm_en = 1'b0;
        alrm_clr = '0;
        m_psc = '0; m_cnt = '0; m_pend = '0; m_tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_cmp[k] = '0; m_per[k] = '0; m_en[k] = 1'b0;
        end

        // Reset state
        run(2);
        check("rst_cnt",  cnt_o, 32'h0);
        check("rst_tick", tick_o, 1'b0);
        check("rst_pend", alrm_pend_o, 4'h0);
        check("rst_irq",  irq_o, 1'b0);
        rst = 1'b0;

        // Prescaler 3 and counter wrap
        psc = 16'd3; cnt_wr = 1'b1; cnt_wdata = 32'hFFFF_FFFE;
        step();
        idle_inputs(); en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("psc_tick_pulse", tick_o, (i == 4));
        end
        check("wrap_ffff", cnt_o, 32'hFFFF_FFFF);
        run(4);
        check("wrap_zero", cnt_o, 32'h0);
        check("wrap_tick", tick_o, 1'b1);
        step();
        check("tick_single", tick_o, 1'b0);

        // One-shot on ch0
        en = 1'b0; psc = '0; cnt_wr = 1'b1; cnt_wdata = '0; alrm_clr = 4'hF;
        set_ch(2'd0, 32'd10, 32'd0, 1'b1);
        step();
        idle_inputs(); en = 1'b1;
        run(10);
        check("oneshot_cnt",  cnt_o, 32'd10);
        check("oneshot_pend", alrm_pend_o[0], 1'b1);
        check("oneshot_irq",  irq_o, 1'b1);
        alrm_clr = 4'b0001; cnt_wr = 1'b1; cnt_wdata = '0;
        step();
        idle_inputs();
        run(12);
        check("oneshot_norefire", alrm_pend_o[0], 1'b0);

        // Periodic with wrap on ch2
        en = 1'b0; cnt_wr = 1'b1; cnt_wdata = 32'hFFFF_FFE0;
        set_ch(2'd2, 32'hFFFF_FFF0, 32'h20, 1'b1);
        step();
        idle_inputs(); en = 1'b1;
        run(16);
        check("per_cnt1",  cnt_o, 32'hFFFF_FFF0);
        check("per_pend1", alrm_pend_o[2], 1'b1);
        check("per_reload", alrm_cmp_o, 32'h10);
        alrm_clr = 4'b0100;
        step();
        idle_inputs();
        run(31);
        check("per_cnt2",  cnt_o, 32'h10);
        check("per_pend2", alrm_pend_o[2], 1'b1);
        check("per_reload2", alrm_cmp_o, 32'h30);

        // Collisions on ch1
        en = 1'b0; cnt_wr = 1'b1; cnt_wdata = 32'h100; alrm_clr = 4'hF;
        set_ch(2'd2, 32'h0, 32'h0, 1'b0);
        step();
        idle_inputs();
        set_ch(2'd1, 32'h105, 32'h0, 1'b1);
        step();
        idle_inputs(); en = 1'b1;
        run(4);
        alrm_clr = 4'b0010;
        step();
        check("setclr_cnt",  cnt_o, 32'h105);
        check("setclr_pend", alrm_pend_o[1], 1'b1);
        step();
        idle_inputs();
        check("clr_next", alrm_pend_o[1], 1'b0);
        set_ch(2'd1, 32'h10A, 32'h0, 1'b1);
        step();
        idle_inputs();
        run(2);
        set_ch(2'd1, 32'h10C, 32'h0, 1'b1);
        step();
        idle_inputs();
        check("wrmatch_cnt",  cnt_o, 32'h10A);
        check("wrmatch_drop", alrm_pend_o[1], 1'b0);
        check("wrmatch_cmp",  alrm_cmp_o, 32'h10C);
        run(2);
        check("wrmatch_new", alrm_pend_o[1], 1'b1);
        alrm_clr = 4'b0010;
        set_ch(2'd1, 32'h200, 32'h0, 1'b1);
        step();
        idle_inputs();
        cnt_wr = 1'b1; cnt_wdata = 32'h200;
        step();
        idle_inputs();
        check("load_cnt",  cnt_o, 32'h200);
        check("load_tick", tick_o, 1'b0);
        check("load_nofire", alrm_pend_o[1], 1'b0);

        // Two channels matching together
        en = 1'b0; cnt_wr = 1'b1; cnt_wdata = '0; alrm_clr = 4'hF;
        set_ch(2'd0, 32'd5, 32'd0, 1'b1);
        step();
        idle_inputs();
        set_ch(2'd3, 32'd5, 32'd0, 1'b1);
        step();
        idle_inputs(); en = 1'b1;
        run(5);
        check("multi_pend", alrm_pend_o, 4'b1001);
        alrm_clr = 4'b0001;
        step();
        idle_inputs();
        check("multi_irq_hold", irq_o, 1'b1);
        check("multi_pend3", alrm_pend_o, 4'b1000);
        alrm_clr = 4'b1000;
        step();
        idle_inputs();
        check("multi_irq_low", irq_o, 1'b0);

        // Reset mid-run
        en = 1'b0; cnt_wr = 1'b1; cnt_wdata = '0; psc = '0;
        set_ch(2'd0, 32'd1, 32'd0, 1'b1);
        step();
        idle_inputs();
        set_ch(2'd2, 32'd1, 32'd0, 1'b1);
        step();
        idle_inputs(); en = 1'b1;
        step();
        check("prerst_pend", alrm_pend_o, 4'b0101);
        psc = 16'd3; cnt_wr = 1'b1;
        step();
        idle_inputs();
        run(2);
        rst = 1'b1;
        step();
        check("midrst_cnt",  cnt_o, 32'h0);
        check("midrst_tick", tick_o, 1'b0);
        check("midrst_pend", alrm_pend_o, 4'h0);
        check("midrst_irq",  irq_o, 1'b0);
        for (int k = 0; k < 4; k++) begin
            alrm_idx = 2'(k);
            #1;
            check("midrst_cmp", alrm_cmp_o, 32'h0);
        end
        rst = 1'b0;
        run(8);
        check("postrst_cnt",  cnt_o, 32'd2);
        check("postrst_pend", alrm_pend_o, 4'h0);

        // Randomised traffic checked against the model
        psc = '0; cnt_wr = 1'b1; cnt_wdata = 32'hFFFF_FF00;
        step();
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 7) != 0);
            rst      = ($urandom_range(0, 199) == 0);
            cnt_wr   = ($urandom_range(0, 31) == 0);
            if (cnt_wr) begin
                psc       = 16'($urandom_range(0, 2));
                cnt_wdata = m_cnt + 32'($urandom_range(0, 40)) - 32'd20;
            end
            alrm_wr  = ($urandom_range(0, 5) == 0);
            alrm_idx = 2'($urandom_range(0, 3));
            alrm_cmp = m_cnt + 32'($urandom_range(0, 12));
            alrm_per = 32'($urandom_range(0, 6));
            alrm_en  = ($urandom_range(0, 3) != 0);
            alrm_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            step();
        end
        rst = 1'b0;
        idle_inputs();
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
